// File: rtl/spi_slave_mem.sv
// spi_slave_mem: SPI slave that bridges an external master to a tx read RAM and an rc write RAM.
// Supports all four CPOL/CPHA modes, any word width and either bit order. SPI_CLK, SPI_SS and
// SPI_MOSI are oversampled in the SysClk domain; no flop is clocked by SPI_CLK.
module spi_slave_mem #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ADDR_W      = 12,
   parameter bit          CPOL        = 1'b0,
   parameter bit          CPHA        = 1'b0,
   parameter bit          MSB_FIRST   = 1'b1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              SysClk,
   input  logic              Reset_n,
   input  logic              SPI_CLK,
   input  logic              SPI_SS,
   input  logic              SPI_MOSI,
   output logic              SPI_MISO,
   output logic              SPI_MISO_oe,
   output logic [ADDR_W-1:0] txMemAddr,
   input  logic [DATA_W-1:0] txMemData,
   output logic [ADDR_W-1:0] rcMemAddr,
   output logic [DATA_W-1:0] rcMemData,
   output logic              rcMemWE,
   output logic              frameDone,
   output logic              frameErr,
   output logic [ADDR_W-1:0] rcWordCount
);

   localparam int unsigned      CNT_W    = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StLoad  = 2'd1;
   localparam logic [1:0] StShift = 2'd2;

   // Pin synchronisers and edge-detect history
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic                   ss_prev_q,   ss_prev_d;

   // Frame state and datapath
   logic [1:0]        state_q,       state_d;
   logic [DATA_W-1:0] shift_tx_q,    shift_tx_d;
   logic [DATA_W-1:0] shift_rc_q,    shift_rc_d;
   logic [DATA_W-1:0] rc_data_q,     rc_data_d;
   logic [CNT_W-1:0]  bit_cnt_q,     bit_cnt_d;
   logic              word_done_q,   word_done_d;
   logic              first_shift_q, first_shift_d;
   logic [ADDR_W-1:0] tx_addr_q,     tx_addr_d;
   logic [ADDR_W-1:0] rc_addr_q,     rc_addr_d;
   logic [ADDR_W-1:0] word_cnt_q,    word_cnt_d;
   logic              oe_q,          oe_d;
   logic              we_q,          we_d;
   logic              frame_done_q,  frame_done_d;
   logic              frame_err_q,   frame_err_d;

   // Decoded events
   logic              sclk_s, ss_s, mosi_s;
   logic              lead_edge, trail_edge;
   logic              sample_ev, shift_ev;
   logic              ss_fall, ss_rise;
   logic [DATA_W-1:0] rc_shifted, tx_shifted;

   // Shift each pin one stage further into the SysClk domain
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SPI_CLK};
      ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SPI_SS};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
      sclk_s      = sclk_sync_q[SYNC_STAGES-1];
      ss_s        = ss_sync_q[SYNC_STAGES-1];
      mosi_s      = mosi_sync_q[SYNC_STAGES-1];
      sclk_prev_d = sclk_s;
      ss_prev_d   = ss_s;
   end

   // Classify synced SPI_CLK/SPI_SS transitions into sample/shift/frame events
   always_comb begin
      // Leading edge leaves the idle level, trailing edge returns to it
      lead_edge  = (sclk_prev_q == CPOL) && (sclk_s != CPOL);
      trail_edge = (sclk_prev_q != CPOL) && (sclk_s == CPOL);
      sample_ev  = CPHA ? trail_edge : lead_edge;
      shift_ev   = CPHA ? lead_edge  : trail_edge;
      ss_fall    = ss_prev_q && !ss_s;
      ss_rise    = !ss_prev_q && ss_s;
   end

   // Shift-register candidates for the configured bit order
   always_comb begin
      if (MSB_FIRST) begin
         rc_shifted = {shift_rc_q[DATA_W-2:0], mosi_s};
         tx_shifted = {shift_tx_q[DATA_W-2:0], 1'b0};
      end else begin
         rc_shifted = {mosi_s, shift_rc_q[DATA_W-1:1]};
         tx_shifted = {1'b0, shift_tx_q[DATA_W-1:1]};
      end
   end

   // Frame FSM and tx/rc datapath next state
   always_comb begin
      state_d       = state_q;
      shift_tx_d    = shift_tx_q;
      shift_rc_d    = shift_rc_q;
      rc_data_d     = rc_data_q;
      bit_cnt_d     = bit_cnt_q;
      word_done_d   = word_done_q;
      first_shift_d = first_shift_q;
      tx_addr_d     = tx_addr_q;
      rc_addr_d     = rc_addr_q;
      word_cnt_d    = word_cnt_q;
      oe_d          = oe_q;
      we_d          = 1'b0;
      frame_done_d  = 1'b0;
      frame_err_d   = 1'b0;

      // Write address and word count advance the cycle after the write strobe
      if (we_q) begin
         rc_addr_d  = rc_addr_q + ADDR_W'(1);
         word_cnt_d = word_cnt_q + ADDR_W'(1);
      end

      case (state_q)
         StIdle: begin
            tx_addr_d = '0;
            oe_d      = 1'b0;
            if (ss_fall) begin
               state_d = StLoad;
            end
         end

         StLoad: begin
            if (ss_rise) begin
               // SS glitch: empty frame, never an error
               state_d      = StIdle;
               frame_done_d = 1'b1;
               oe_d         = 1'b0;
            end else begin
               shift_tx_d    = txMemData;
               tx_addr_d     = ADDR_W'(1);
               rc_addr_d     = '0;
               word_cnt_d    = '0;
               bit_cnt_d     = '0;
               word_done_d   = 1'b0;
               first_shift_d = 1'b1;
               oe_d          = 1'b1;
               state_d       = StShift;
            end
         end

         StShift: begin
            if (ss_rise) begin
               // SS wins over any coincident clock event; a partial word is dropped
               state_d      = StIdle;
               frame_done_d = 1'b1;
               frame_err_d  = (bit_cnt_q != '0);
               bit_cnt_d    = '0;
               word_done_d  = 1'b0;
               oe_d         = 1'b0;
               tx_addr_d    = '0;
            end else begin
               if (sample_ev) begin
                  shift_rc_d = rc_shifted;
                  if (bit_cnt_q == LAST_BIT) begin
                     we_d        = 1'b1;
                     rc_data_d   = rc_shifted;
                     bit_cnt_d   = '0;
                     word_done_d = 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  end
               end
               if (shift_ev) begin
                  first_shift_d = 1'b0;
                  if (word_done_q) begin
                     // Next tx word was prefetched at tx_addr_q since the previous load
                     shift_tx_d  = txMemData;
                     tx_addr_d   = tx_addr_q + ADDR_W'(1);
                     word_done_d = 1'b0;
                  end else if (CPHA && first_shift_q) begin
                     // First bit is already on MISO; the opening leading edge must not move it
                     shift_tx_d = shift_tx_q;
                  end else begin
                     shift_tx_d = tx_shifted;
                  end
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge SysClk or negedge Reset_n) begin
      if (!Reset_n) begin
         sclk_sync_q   <= '0;
         ss_sync_q     <= '0;
         mosi_sync_q   <= '0;
         sclk_prev_q   <= 1'b0;
         ss_prev_q     <= 1'b0;
         state_q       <= StIdle;
         shift_tx_q    <= '0;
         shift_rc_q    <= '0;
         rc_data_q     <= '0;
         bit_cnt_q     <= '0;
         word_done_q   <= 1'b0;
         first_shift_q <= 1'b0;
         tx_addr_q     <= '0;
         rc_addr_q     <= '0;
         word_cnt_q    <= '0;
         oe_q          <= 1'b0;
         we_q          <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         sclk_sync_q   <= sclk_sync_d;
         ss_sync_q     <= ss_sync_d;
         mosi_sync_q   <= mosi_sync_d;
         sclk_prev_q   <= sclk_prev_d;
         ss_prev_q     <= ss_prev_d;
         state_q       <= state_d;
         shift_tx_q    <= shift_tx_d;
         shift_rc_q    <= shift_rc_d;
         rc_data_q     <= rc_data_d;
         bit_cnt_q     <= bit_cnt_d;
         word_done_q   <= word_done_d;
         first_shift_q <= first_shift_d;
         tx_addr_q     <= tx_addr_d;
         rc_addr_q     <= rc_addr_d;
         word_cnt_q    <= word_cnt_d;
         oe_q          <= oe_d;
         we_q          <= we_d;
         frame_done_q  <= frame_done_d;
         frame_err_q   <= frame_err_d;
      end
   end

   // Output drive; MISO is forced low outside an active shift phase
   always_comb begin
      SPI_MISO = 1'b0;
      if (state_q == StShift) begin
         SPI_MISO = MSB_FIRST ? shift_tx_q[DATA_W-1] : shift_tx_q[0];
      end
      SPI_MISO_oe = oe_q;
      txMemAddr   = tx_addr_q;
      rcMemAddr   = rc_addr_q;
      rcMemData   = rc_data_q;
      rcMemWE     = we_q;
      frameDone   = frame_done_q;
      frameErr    = frame_err_q;
      rcWordCount = word_cnt_q;
   end

endmodule
